// File: rtl/stump_ctrl_pkg.sv
// rtl/stump_ctrl_pkg.sv - shared encodings for the Stump control unit
// Purpose: state encodings, opcodes, branch condition codes and ir field
// positions used by stump_control and stump_cond_eval. No ports.
package stump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10,
    ST_UNUSED  = 2'b11
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_NV = 4'h1;
  localparam logic [3:0] COND_HI = 4'h2;
  localparam logic [3:0] COND_LS = 4'h3;
  localparam logic [3:0] COND_CC = 4'h4;
  localparam logic [3:0] COND_CS = 4'h5;
  localparam logic [3:0] COND_NE = 4'h6;
  localparam logic [3:0] COND_EQ = 4'h7;
  localparam logic [3:0] COND_VC = 4'h8;
  localparam logic [3:0] COND_VS = 4'h9;
  localparam logic [3:0] COND_PL = 4'hA;
  localparam logic [3:0] COND_MI = 4'hB;
  localparam logic [3:0] COND_GE = 4'hC;
  localparam logic [3:0] COND_LT = 4'hD;
  localparam logic [3:0] COND_GT = 4'hE;
  localparam logic [3:0] COND_LE = 4'hF;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int TYPE_BIT   = 12;
  localparam int S_BIT      = 11;
  localparam int DEST_MSB   = 10;
  localparam int DEST_LSB   = 8;
  localparam int SRCA_MSB   = 7;
  localparam int SRCA_LSB   = 5;
  localparam int SRCB_MSB   = 4;
  localparam int SRCB_LSB   = 2;
  localparam int SHIFT_MSB  = 1;
  localparam int SHIFT_LSB  = 0;
  localparam int COND_MSB   = 11;
  localparam int COND_LSB   = 8;

  localparam logic [2:0] REG_PC = 3'd7;

endpackage

// File: rtl/stump_cond_eval.sv
// rtl/stump_cond_eval.sv - branch condition evaluator
// Purpose: decides whether a Bcc condition holds for the current flags.
// Ports: cond[3:0] condition code, cc[3:0] flags {N,Z,V,C}, taken result.
module stump_cond_eval
  import stump_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);

  logic n, z, v, c;
  assign n = cc[3];
  assign z = cc[2];
  assign v = cc[1];
  assign c = cc[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      COND_HI: taken = ~c & ~z;
      COND_LS: taken = c | z;
      COND_CC: taken = ~c;
      COND_CS: taken = c;
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_VC: taken = ~v;
      COND_VS: taken = v;
      COND_PL: taken = ~n;
      COND_MI: taken = n;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/stump_control.sv
// rtl/stump_control.sv - Stump instruction sequencer and decoder
// Purpose: FETCH/EXECUTE/MEMORY sequencer driving ALU, register file,
// PC and memory port controls.
// Ports: clk, rst (sync active-high); ir, cc, mem_ready inputs;
// state, fetch, pc_inc, alu_func, opB_mux_sel, ext_op, shift_op,
// srcA, srcB, dest, reg_write, cc_en, mem_ren, mem_wen outputs.
module stump_control
  import stump_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
  input  logic        mem_ready,
  output logic [1:0]  state,
  output logic        fetch,
  output logic        pc_inc,
  output logic [2:0]  alu_func,
  output logic        opB_mux_sel,
  output logic        ext_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [2:0]  dest,
  output logic        reg_write,
  output logic        cc_en,
  output logic        mem_ren,
  output logic        mem_wen
);

  state_t     state_q, state_d;
  logic       taken;
  logic [2:0] opcode;
  logic       imm_type;

  assign state    = state_q;
  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign imm_type = ir[TYPE_BIT];

  stump_cond_eval u_cond_eval (
    .cond  (ir[COND_MSB:COND_LSB]),
    .cc    (cc),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = ST_FETCH;
    fetch       = 1'b0;
    pc_inc      = 1'b0;
    alu_func    = OP_ADD;
    opB_mux_sel = 1'b0;
    ext_op      = 1'b0;
    shift_op    = 2'b00;
    srcA        = 3'd0;
    srcB        = 3'd0;
    dest        = 3'd0;
    reg_write   = 1'b0;
    cc_en       = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // IR load and PC increment only commit at the edge with mem_ready
        mem_ren = 1'b1;
        fetch   = 1'b1;
        pc_inc  = 1'b1;
        state_d = mem_ready ? ST_EXECUTE : ST_FETCH;
      end
      ST_EXECUTE: begin
        srcA        = ir[SRCA_MSB:SRCA_LSB];
        srcB        = ir[SRCB_MSB:SRCB_LSB];
        dest        = ir[DEST_MSB:DEST_LSB];
        opB_mux_sel = imm_type;
        shift_op    = imm_type ? 2'b00 : ir[SHIFT_MSB:SHIFT_LSB];
        case (opcode)
          OP_LDST: begin
            // address calculation only; the datapath latches the sum
            alu_func = OP_ADD;
            state_d  = ST_MEMORY;
          end
          OP_BCC: begin
            // PC-relative: R7 <= R7 + sext(ir[7:0]) when the condition holds
            alu_func    = OP_ADD;
            srcA        = REG_PC;
            srcB        = 3'd0;
            dest        = REG_PC;
            opB_mux_sel = 1'b1;
            ext_op      = 1'b1;
            shift_op    = 2'b00;
            reg_write   = taken;
          end
          default: begin
            alu_func  = opcode;
            reg_write = 1'b1;
            cc_en     = ir[S_BIT];
          end
        endcase
      end
      ST_MEMORY: begin
        if (ir[S_BIT]) begin
          mem_wen = 1'b1;
          srcA    = ir[DEST_MSB:DEST_LSB];
        end else begin
          mem_ren   = 1'b1;
          dest      = ir[DEST_MSB:DEST_LSB];
          reg_write = mem_ready;
        end
        state_d = mem_ready ? ST_FETCH : ST_MEMORY;
      end
      default: state_d = ST_FETCH;
    endcase

    // reset suppresses every architectural side effect in the current cycle
    if (rst) begin
      reg_write = 1'b0;
      cc_en     = 1'b0;
      mem_wen   = 1'b0;
    end
  end

endmodule

// File: tb/tb_stump_control.sv
// tb/tb_stump_control.sv - directed self-checking bench for stump_control
module tb_stump_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic [3:0]  cc;
  logic        mem_ready;
  logic [1:0]  state;
  logic        fetch, pc_inc, opB_mux_sel, ext_op;
  logic [2:0]  alu_func, srcA, srcB, dest;
  logic [1:0]  shift_op;
  logic        reg_write, cc_en, mem_ren, mem_wen;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stump_control dut (
    .clk(clk), .rst(rst), .ir(ir), .cc(cc), .mem_ready(mem_ready),
    .state(state), .fetch(fetch), .pc_inc(pc_inc), .alu_func(alu_func),
    .opB_mux_sel(opB_mux_sel), .ext_op(ext_op), .shift_op(shift_op),
    .srcA(srcA), .srcB(srcB), .dest(dest), .reg_write(reg_write),
    .cc_en(cc_en), .mem_ren(mem_ren), .mem_wen(mem_wen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: odd condition codes are the complement of the even one below.
  function automatic logic ref_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[3:1])
      3'd0: base = 1'b1;
      3'd1: base = !c && !z;
      3'd2: base = !c;
      3'd3: base = !z;
      3'd4: base = !v;
      3'd5: base = !n;
      3'd6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; ir = 16'h0000; cc = 4'h0;
    tick(); tick();
    tests_run++;
    if ({state, fetch, pc_inc, mem_ren, mem_wen, reg_write, cc_en, alu_func, srcA, dest} !== {2'b00, 3'b111, 3'b000, 3'd0, 3'd0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: state=%b fetch=%b pc_inc=%b mem_ren=%b mem_wen=%b reg_write=%b cc_en=%b, required state=00 fetch/pc_inc/mem_ren=1 others 0",
               state, fetch, pc_inc, mem_ren, mem_wen, reg_write, cc_en);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (state !== 2'b00 || fetch !== 1'b1 || mem_ren !== 1'b1 || reg_write !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_fetch[%0d]: state=%b fetch=%b mem_ren=%b reg_write=%b, required 00 1 1 0", i, state, fetch, mem_ren, reg_write);
      end
    end
  endtask

  task automatic test_add();
    mem_ready = 1'b1;
    tick();
    ir = 16'h0A45; mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({state, alu_func, srcA, srcB, dest, reg_write, cc_en, opB_mux_sel, shift_op} !== {2'b01, 3'd0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 2'b01}) begin
      tests_failed++;
      $display("FAIL add_execute: state=%b alu=%0d srcA=%0d srcB=%0d dest=%0d rw=%b cc_en=%b opB=%b sh=%b, required 01 0 2 1 2 1 1 0 01",
               state, alu_func, srcA, srcB, dest, reg_write, cc_en, opB_mux_sel, shift_op);
    end
    tick();
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL add_return: state=%b, required 00", state);
    end
  endtask

  task automatic test_adc_imm();
    mem_ready = 1'b1;
    tick();
    ir = 16'h3D2B;
    #1;
    tests_run++;
    if ({alu_func, srcA, srcB, dest, reg_write, cc_en, opB_mux_sel, ext_op, shift_op} !== {3'd1, 3'd1, 3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL adc_imm_execute: alu=%0d srcA=%0d srcB=%0d dest=%0d rw=%b cc_en=%b opB=%b ext=%b sh=%b, required 1 1 2 5 1 1 1 0 00",
               alu_func, srcA, srcB, dest, reg_write, cc_en, opB_mux_sel, ext_op, shift_op);
    end
    tick();
  endtask

  task automatic test_load_stall();
    logic [1:0] seq [6];
    logic       rw  [6];
    logic [1:0] exp_seq [6];
    logic       exp_rw  [6];
    exp_seq = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    exp_rw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ir = 16'hC3E1; mem_ready = 1'b1;
    #1; seq[0] = state; rw[0] = reg_write;
    tick(); mem_ready = 1'b1;
    #1; seq[1] = state; rw[1] = reg_write;
    tests_run++;
    if (alu_func !== 3'd0 || cc_en !== 1'b0 || srcA !== 3'd7) begin
      tests_failed++;
      $display("FAIL ld_address: alu=%0d cc_en=%b srcA=%0d, required 0 0 7", alu_func, cc_en, srcA);
    end
    tick(); mem_ready = 1'b0;
    #1; seq[2] = state; rw[2] = reg_write;
    tick();
    #1; seq[3] = state; rw[3] = reg_write;
    tick(); mem_ready = 1'b1;
    #1; seq[4] = state; rw[4] = reg_write;
    tests_run++;
    if (dest !== 3'd3 || mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL ld_memory_ctrl: dest=%0d mem_ren=%b mem_wen=%b, required 3 1 0", dest, mem_ren, mem_wen);
    end
    tick(); mem_ready = 1'b0;
    #1; seq[5] = state; rw[5] = reg_write;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (seq[i] !== exp_seq[i] || rw[i] !== exp_rw[i]) begin
        tests_failed++;
        $display("FAIL ld_sequence[%0d]: state=%b reg_write=%b, required %b %b", i, seq[i], rw[i], exp_seq[i], exp_rw[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] flags [2];
    logic       exp_rw [2];
    flags  = '{4'b0100, 4'b0000};
    exp_rw = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'b1;
      tick();
      ir = 16'hE7FE; cc = flags[k];
      #1;
      tests_run++;
      if ({state, reg_write, dest, srcA, ext_op, opB_mux_sel, alu_func, shift_op, cc_en} !== {2'b01, exp_rw[k], 3'd7, 3'd7, 1'b1, 1'b1, 3'd0, 2'b00, 1'b0}) begin
        tests_failed++;
        $display("FAIL beq_cc%b: state=%b rw=%b dest=%0d srcA=%0d ext=%b opB=%b alu=%0d sh=%b cc_en=%b, required 01 %b 7 7 1 1 0 00 0",
                 flags[k], state, reg_write, dest, srcA, ext_op, opB_mux_sel, alu_func, shift_op, cc_en, exp_rw[k]);
      end
      tick();
    end
  endtask

  task automatic test_cond_sweep();
    logic exp;
    mem_ready = 1'b1;
    for (int cd = 0; cd < 16; cd++) begin
      for (int f = 0; f < 16; f++) begin
        tick();
        ir = {3'b111, 1'b0, cd[3:0], 8'h05};
        cc = f[3:0];
        #1;
        exp = ref_taken(cd[3:0], f[3:0]);
        tests_run++;
        if (state !== 2'b01 || reg_write !== exp) begin
          tests_failed++;
          $display("FAIL cond_sweep cond=%h cc=%b: state=%b taken=%b, required 01 %b", cd[3:0], f[3:0], state, reg_write, exp);
        end
        tick();
      end
    end
  endtask

  task automatic test_store_reset();
    ir = 16'hC800; mem_ready = 1'b1;
    tick();
    tick(); mem_ready = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'b10 || mem_wen !== 1'b1 || mem_ren !== 1'b0 || reg_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL st_memory: state=%b mem_wen=%b mem_ren=%b rw=%b, required 10 1 0 0", state, mem_wen, mem_ren, reg_write);
    end
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    tests_run++;
    if (mem_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL st_reset_wen: mem_wen=%b, required 0", mem_wen);
    end
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL st_reset_state: state=%b, required 00", state);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc_imm();
    test_load_stall();
    test_branch();
    test_cond_sweep();
    test_store_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
